// File: rtl/rule_unpacker.sv
// rtl/rule_unpacker.sv - unpacks 32-slot rule-ID flits into a one-rule-per-cycle stream
// Delimits packets with sop/eop, emits a no-match marker for rule-less packets, keeps stats.
module rule_unpacker (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_usr_sop,
  input  logic         in_usr_eop,
  input  logic [511:0] in_usr_data,
  input  logic [5:0]   in_usr_empty,
  input  logic         in_usr_valid,
  output logic         in_usr_ready,
  output logic         out_rule_valid,
  input  logic         out_rule_ready,
  output logic [15:0]  out_rule_data,
  output logic         out_rule_sop,
  output logic         out_rule_eop,
  output logic [31:0]  stats_rule,
  output logic [31:0]  stats_pkt,
  output logic [31:0]  stats_err
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state, state_next;
  logic [511:0]  data_q;
  logic          eop_q;
  logic [31:0]   mask_q;
  logic          marker_q;
  logic          first_pending;
  logic          pkt_open;

  logic [31:0]   in_mask;
  logic [4:0]    enc_idx;
  logic [15:0]   enc_rule;
  logic [31:0]   rest_mask;
  logic          in_xfer;
  logic          out_xfer;
  logic          fp_new;

  assign in_xfer  = in_usr_valid & in_usr_ready;
  assign out_xfer = out_rule_valid & out_rule_ready;
  assign fp_new   = in_usr_sop | first_pending;

  // A slot counts only if nonzero and, on the eop flit, both of its bytes are valid.
  always_comb begin
    in_mask = '0;
    for (int k = 0; k < 32; k++) begin
      if ((in_usr_data[511-16*k -: 16] != 16'd0) &&
          (!in_usr_eop || ((2*k + 2 + int'(in_usr_empty)) <= 64)))
        in_mask[k] = 1'b1;
    end
  end

  always_comb begin
    enc_idx  = '0;
    enc_rule = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mask_q[i]) begin
        enc_idx  = 5'(i);
        enc_rule = data_q[511-16*i -: 16];
      end
    end
  end

  assign rest_mask = mask_q & ~(32'd1 << enc_idx);

  always_comb begin
    state_next     = state;
    in_usr_ready   = 1'b0;
    out_rule_valid = 1'b0;
    out_rule_data  = '0;
    out_rule_sop   = 1'b0;
    out_rule_eop   = 1'b0;
    case (state)
      IDLE: begin
        in_usr_ready = 1'b1;
        if (in_usr_valid) state_next = SCAN;
      end
      SCAN: begin
        if (marker_q) begin
          out_rule_valid = 1'b1;
          out_rule_sop   = 1'b1;
          out_rule_eop   = 1'b1;
          if (out_rule_ready) state_next = IDLE;
        end else if (mask_q != '0) begin
          out_rule_valid = 1'b1;
          out_rule_data  = enc_rule;
          out_rule_sop   = first_pending;
          out_rule_eop   = eop_q && (rest_mask == '0);
          if (out_rule_ready && (rest_mask == '0)) state_next = IDLE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      in_usr_ready   = 1'b0;
      out_rule_valid = 1'b0;
      out_rule_data  = '0;
      out_rule_sop   = 1'b0;
      out_rule_eop   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      data_q        <= '0;
      eop_q         <= 1'b0;
      mask_q        <= '0;
      marker_q      <= 1'b0;
      first_pending <= 1'b0;
      pkt_open      <= 1'b0;
      stats_rule    <= '0;
      stats_pkt     <= '0;
      stats_err     <= '0;
    end else begin
      state <= state_next;
      if (in_xfer) begin
        data_q        <= in_usr_data;
        eop_q         <= in_usr_eop;
        mask_q        <= in_mask;
        marker_q      <= in_usr_eop && (in_mask == '0) && fp_new;
        first_pending <= fp_new;
        pkt_open      <= in_usr_eop ? 1'b0 : (in_usr_sop | pkt_open);
        // A new sop on an open packet abandons the old one without closing it.
        if (in_usr_sop && pkt_open) stats_err <= stats_err + 32'd1;
      end
      if (out_xfer) begin
        mask_q        <= marker_q ? mask_q : rest_mask;
        marker_q      <= 1'b0;
        first_pending <= 1'b0;
        if (out_rule_data != 16'd0) stats_rule <= stats_rule + 32'd1;
        if (out_rule_eop) stats_pkt <= stats_pkt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_rule_unpacker.sv
// tb/tb_rule_unpacker.sv - self-checking bench for rule_unpacker
// Packet-level model builds the expected beat queue; a monitor checks every output transfer.
module tb_rule_unpacker;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_usr_sop, in_usr_eop, in_usr_valid, in_usr_ready;
  logic [511:0] in_usr_data;
  logic [5:0]   in_usr_empty;
  logic         out_rule_valid, out_rule_ready;
  logic [15:0]  out_rule_data;
  logic         out_rule_sop, out_rule_eop;
  logic [31:0]  stats_rule, stats_pkt, stats_err;

  always #5 clk = ~clk;

  rule_unpacker dut (
    .clk(clk), .rst(rst),
    .in_usr_sop(in_usr_sop), .in_usr_eop(in_usr_eop),
    .in_usr_data(in_usr_data), .in_usr_empty(in_usr_empty),
    .in_usr_valid(in_usr_valid), .in_usr_ready(in_usr_ready),
    .out_rule_valid(out_rule_valid), .out_rule_ready(out_rule_ready),
    .out_rule_data(out_rule_data), .out_rule_sop(out_rule_sop), .out_rule_eop(out_rule_eop),
    .stats_rule(stats_rule), .stats_pkt(stats_pkt), .stats_err(stats_err)
  );

  typedef struct {
    logic [15:0] d;
    logic        s;
    logic        e;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    passed = 0;
  bit    m_open, m_fp;
  int    m_rule, m_pkt, m_err;
  bit    rdy_mode;
  bit    rdy_level;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_open = 0; m_fp = 0; m_rule = 0; m_pkt = 0; m_err = 0;
  endtask

  // Expected beats for one flit, straight from the packet/slot rules.
  task automatic model_flit(input logic s, input logic e, input logic [511:0] d, input logic [5:0] emp);
    int    bytes;
    beat_t lst[$];
    beat_t b;
    bytes = e ? 64 - int'(emp) : 64;
    if (s) begin
      if (m_open) m_err++;
      m_open = 1;
      m_fp   = 1;
    end
    for (int k = 0; k < 32; k++) begin
      if (d[511-16*k -: 16] != 16'd0 && (2*k + 2) <= bytes) begin
        b.d = d[511-16*k -: 16]; b.s = 0; b.e = 0;
        lst.push_back(b);
      end
    end
    if (lst.size() > 0) begin
      lst[0].s = m_fp;
      lst[lst.size()-1].e = e;
      m_fp = 0;
      foreach (lst[i]) begin
        exp_q.push_back(lst[i]);
        m_rule++;
        if (lst[i].e) m_pkt++;
      end
    end else if (e && m_fp) begin
      b.d = 16'd0; b.s = 1; b.e = 1;
      exp_q.push_back(b);
      m_pkt++;
      m_fp = 0;
    end
    if (e) m_open = 0;
  endtask

  task automatic send(input logic s, input logic e, input logic [511:0] d, input logic [5:0] emp);
    int n;
    bit done;
    @(posedge clk); #1;
    model_flit(s, e, d, emp);
    in_usr_sop = s; in_usr_eop = e; in_usr_data = d; in_usr_empty = emp; in_usr_valid = 1;
    done = 0; n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (in_usr_ready && !rst) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    in_usr_valid = 0; in_usr_sop = 0; in_usr_eop = 0;
    if (!done) chk("send_timeout", 0, 0, 1);
  endtask

  task automatic drain();
    int  n;
    bit  done;
    done = 0; n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && in_usr_ready && !out_rule_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 0, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    @(negedge clk);
    chk("rst_outputs", !out_rule_valid && !in_usr_ready && out_rule_data == 0 && !out_rule_sop && !out_rule_eop,
        {out_rule_valid, in_usr_ready, out_rule_data}, 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic chk_stats(input string name);
    chk({name, "_rule"}, stats_rule == m_rule, stats_rule, m_rule);
    chk({name, "_pkt"},  stats_pkt  == m_pkt,  stats_pkt,  m_pkt);
    chk({name, "_err"},  stats_err  == m_err,  stats_err,  m_err);
  endtask

  initial begin
    out_rule_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode) out_rule_ready = ~out_rule_ready;
      else out_rule_ready = rdy_level;
    end
  end

  // Monitor: every output transfer must match the model; stalled beats must hold.
  bit          prev_stall = 0;
  logic [15:0] prev_d;
  logic        prev_s, prev_e;
  beat_t       got;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold", out_rule_valid && out_rule_data == prev_d && out_rule_sop == prev_s && out_rule_eop == prev_e,
            {out_rule_valid, out_rule_data, out_rule_sop, out_rule_eop}, {1'b1, prev_d, prev_s, prev_e});
      if (out_rule_valid && out_rule_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 0, {out_rule_data, out_rule_sop, out_rule_eop}, 0);
        end else begin
          got = exp_q.pop_front();
          chk("beat", out_rule_data == got.d && out_rule_sop == got.s && out_rule_eop == got.e,
              {out_rule_data, out_rule_sop, out_rule_eop}, {got.d, got.s, got.e});
        end
      end
      prev_stall = out_rule_valid && !out_rule_ready;
      prev_d = out_rule_data; prev_s = out_rule_sop; prev_e = out_rule_eop;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [511:0] d;
  logic [15:0]  lit_d[3];
  logic         lit_s[3];
  logic         lit_e[3];
  int           seen;

  initial begin
    rst = 1; in_usr_sop = 0; in_usr_eop = 0; in_usr_valid = 0;
    in_usr_data = '0; in_usr_empty = '0;
    rdy_mode = 0; rdy_level = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("reset_ready", in_usr_ready == 1, in_usr_ready, 1);
    chk("reset_stats", stats_rule == 0 && stats_pkt == 0 && stats_err == 0, {stats_rule, stats_pkt}, 0);

    // single flit, slots 0/5/31, beats on cycles +1..+3
    do_reset();
    d = '0;
    d[511-16*0 -: 16] = 16'h0011; d[511-16*5 -: 16] = 16'h0022; d[511-16*31 -: 16] = 16'h0033;
    lit_d[0] = 16'h0011; lit_d[1] = 16'h0022; lit_d[2] = 16'h0033;
    lit_s[0] = 1; lit_s[1] = 0; lit_s[2] = 0;
    lit_e[0] = 0; lit_e[1] = 0; lit_e[2] = 1;
    send(1, 1, d, 6'd0);
    chk("model_t1_size", exp_q.size() == 3, exp_q.size(), 3);
    if (exp_q.size() == 3)
      chk("model_t1_beats", exp_q[0].d == 16'h0011 && exp_q[0].s && exp_q[2].d == 16'h0033 && exp_q[2].e,
          {exp_q[0].d, exp_q[2].d}, {16'h0011, 16'h0033});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_latency", out_rule_valid && out_rule_data == lit_d[i] && out_rule_sop == lit_s[i] && out_rule_eop == lit_e[i],
          {out_rule_valid, out_rule_data, out_rule_sop, out_rule_eop}, {1'b1, lit_d[i], lit_s[i], lit_e[i]});
    end
    drain();
    chk("t1_stats_lit", stats_rule == 3 && stats_pkt == 1, {stats_rule, stats_pkt}, {32'd3, 32'd1});
    chk_stats("t1");

    // all-zero single flit -> no-match marker
    do_reset();
    send(1, 1, '0, 6'd0);
    drain();
    chk("t2_stats_lit", stats_rule == 0 && stats_pkt == 1, {stats_rule, stats_pkt}, {32'd0, 32'd1});
    chk_stats("t2");

    // empty=61: slot 1 is partial and dropped
    do_reset();
    d = '0;
    d[511-16*0 -: 16] = 16'h00aa; d[511-16*1 -: 16] = 16'h00bb;
    send(1, 1, d, 6'd61);
    chk("model_t3", exp_q.size() == 1 && exp_q[0].d == 16'h00aa && exp_q[0].e, exp_q.size(), 1);
    drain();
    chk_stats("t3");

    // two-flit packet with toggling ready
    do_reset();
    rdy_mode = 1;
    d = '0; d[511-16*3 -: 16] = 16'h0001;
    send(1, 0, d, 6'd0);
    drain();
    d = '0; d[511-16*7 -: 16] = 16'h0002;
    send(0, 1, d, 6'd0);
    drain();
    rdy_mode = 0;
    chk("t4_stats_lit", stats_rule == 2 && stats_pkt == 1, {stats_rule, stats_pkt}, {32'd2, 32'd1});
    chk_stats("t4");

    // sop on open packet -> error, second packet unpacked
    do_reset();
    d = '0; d[511 -: 16] = 16'h0005;
    send(1, 0, d, 6'd0);
    drain();
    d = '0; d[511-16*2 -: 16] = 16'h0006;
    send(1, 1, d, 6'd0);
    drain();
    chk("t5_err_lit", stats_err == 1 && stats_pkt == 1, {stats_err, stats_pkt}, {32'd1, 32'd1});
    chk_stats("t5");

    // empty non-eop flit, then empty eop flit -> single marker
    do_reset();
    send(1, 0, '0, 6'd0);
    drain();
    send(0, 1, '0, 6'd2);
    drain();
    chk_stats("t7");

    // reset mid-SCAN with 10 rules pending
    do_reset();
    rdy_level = 0;
    d = '0;
    for (int k = 0; k < 10; k++) d[511-16*k -: 16] = 16'h0100 + 16'(k);
    send(1, 1, d, 6'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    @(negedge clk);
    chk("t6_rst_outputs", !out_rule_valid && !in_usr_ready, {out_rule_valid, in_usr_ready}, 0);
    @(posedge clk); #1;
    rst = 0;
    rdy_level = 1;
    @(negedge clk);
    chk("t6_ready_after_rst", in_usr_ready == 1, in_usr_ready, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_rule_valid) seen++;
    end
    chk("t6_no_beats", seen == 0, seen, 0);
    chk("t6_stats_zero", stats_rule == 0 && stats_pkt == 0 && stats_err == 0, {stats_rule, stats_pkt, stats_err}, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rule_unpacker.md
RULE_UNPACKER -- requirements
Module: rule_unpacker

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic rising-edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_usr_sop, in_usr_eop  in  1 each  string-matcher rule-stream packet delimiters.
REQ-004 SHALL have ports: in_usr_data  in  512  32 rule-ID slots of 16 b; slot 0 = data[511:496], slot k = data[511-16k -: 16].
REQ-005 SHALL have ports: in_usr_empty  in  6  unused bytes on eop flit, counted from the LSB end.
REQ-006 SHALL have ports: in_usr_valid  in  1 / in_usr_ready  out  1  Avalon-ST handshake.
REQ-007 SHALL have ports: out_rule_valid  out  1 / out_rule_ready  in  1  output handshake.
REQ-008 SHALL have ports: out_rule_data  out  16  rule ID; out_rule_sop, out_rule_eop  out  1 each.
REQ-009 SHALL have ports: stats_rule  out  32 / stats_pkt  out  32 / stats_err  out  32  counters.
REQ-010 SHALL have one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-011 SHALL define a transfer as valid&ready high at one rising clk edge, on either port.
REQ-012 SHALL use FSM states IDLE and SCAN; IDLE SHALL drive in_usr_ready=1 and SCAN SHALL drive it 0.
REQ-013 SHALL, in IDLE on an input transfer, latch data, eop and a 32-bit slot mask, then enter SCAN next cycle.
REQ-014 SHALL set mask bit k when slot k is nonzero and, on an eop flit, 2k+2 <= 64-empty; partial slots from odd empty SHALL be cleared.
REQ-015 SHALL, in SCAN, drive out_rule_valid=1 with the lowest-index set mask slot (priority encoder), one rule per cycle.
REQ-016 SHALL clear the emitted bit on each output transfer and update to the next set slot the following cycle without a bubble.
REQ-017 SHALL hold out_rule_data/sop/eop stable while out_rule_valid=1 and out_rule_ready=0.
REQ-018 SHALL assert out_rule_sop on the first rule emitted after a packet start, tracked by a first_pending flag set on in_usr_sop.
REQ-019 SHALL assert out_rule_eop on the last set slot of an eop flit.
REQ-020 SHALL, for a non-eop flit with empty mask, spend 1 SCAN cycle with out_rule_valid=0 and return to IDLE.
REQ-021 SHALL, for an eop flit when the whole packet produced no rule, emit a single beat data=0, sop=1, eop=1 (no-match marker).
REQ-022 SHALL return to IDLE on the cycle after the final output transfer of a flit; latency from input transfer to first out_rule_valid SHALL be 1 cycle.
REQ-023 SHALL, when in_usr_sop arrives while a packet is open (no prior eop), increment stats_err and restart packet state; the old packet SHALL get no eop or marker.
REQ-024 SHALL increment stats_rule on each output transfer with data!=0.
REQ-025 SHALL increment stats_pkt on each output transfer with eop=1.
REQ-026 SHALL let all counters wrap modulo 2^32 without saturation.
REQ-027 SHALL treat a single-flit packet (sop&eop) per REQ-018/019/021 in one SCAN pass.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE with mask, first_pending, packet-open flag and all stats set to 0.
REQ-029 SHALL hold out_rule_valid=0, out_rule_data=0, sop=eop=0 and in_usr_ready=0 while rst=1.
REQ-030 SHALL discard any in-flight flit on reset mid-SCAN, emitting no further beats of it after rst falls.

Verification
REQ-031 SHALL pass: single flit sop/eop, empty=0, slots 0,5,31 = 0x0011,0x0022,0x0033, ready=1 -> 3 beats on cycles +1..+3; sop on 0x0011, eop on 0x0033; stats_rule=3, stats_pkt=1.
REQ-032 SHALL pass: single flit sop/eop, all slots 0 -> one beat data=0, sop=eop=1; stats_rule=0, stats_pkt=1.
REQ-033 SHALL pass: eop flit, empty=61, slots 0,1 nonzero -> only slot 0 emitted (slot 1 partial), with eop.
REQ-034 SHALL pass: 2-flit packet, rules 0x0001 in flit 1 and 0x0002 in flit 2, out_rule_ready toggling 1/0 -> data stable while stalled, sop on 0x0001, eop on 0x0002, no duplicates.
REQ-035 SHALL pass: sop flit without eop, then new sop flit -> stats_err=1 and the second packet is unpacked normally.
REQ-036 SHALL pass: rst pulsed in SCAN with 10 rules pending -> no beats after reset, all counters 0, in_usr_ready=1 the first cycle after rst falls.
